// File: rtl/calc_engine.sv
// Sequential calculator (add/sub/shift-add mul/restoring div) with double-dabble
// BCD conversion and a multiplexed seven-segment scanner. Optional: CALC_OVF_BLINK_EN.
module calc_engine #(
  parameter int W        = 7,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [1:0]        op,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    result,
  output logic              negative,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int CW = $clog2(2*W+1);
  localparam int BW = 4*DIGITS;
  localparam int SW = $clog2(SCAN_DIV+1);
  localparam int DW = $clog2(DIGITS);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] MAX_NEG = pow10(DIGITS-1) - 64'd1;

  function automatic logic [BW-1:0] dab(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b1000000;
      4'd1: dec7 = 7'b1111001;
      4'd2: dec7 = 7'b0100100;
      4'd3: dec7 = 7'b0110000;
      4'd4: dec7 = 7'b0011001;
      4'd5: dec7 = 7'b0010010;
      4'd6: dec7 = 7'b0000010;
      4'd7: dec7 = 7'b1111000;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0010000;
      default: dec7 = 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;
  state_t state, nxt;

  logic [1:0]     op_r;
  logic [2*W-1:0] acc, opa, mag, mag_sh;
  logic [W-1:0]   opb;
  logic [W:0]     rs;
  logic           neg_r, dz, ovf_c, calc_last, conv_last;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bcd, bcd_adj, disp;
  logic [63:0]    mag64;

  // Divide keeps the quotient in opa[W-1:0]; everything else ends up in acc.
  assign dz        = (op_r == OP_DIV) && (opb == '0);
  assign mag       = (op_r == OP_DIV) ? {{W{1'b0}}, opa[W-1:0]} : acc;
  assign mag64     = 64'(mag);
  assign ovf_c     = dz || (mag64 > MAX_POS) || (neg_r && (mag64 > MAX_NEG));
  assign calc_last = !op_r[1] || (cnt == CW'(W-1));
  assign conv_last = (cnt == CW'(2*W-1));
  assign mag_sh    = mag << cnt;
  assign rs        = {acc[W-1:0], opa[W-1]};
  assign bcd_adj   = dab(bcd);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = CALC;
      CALC: if (calc_last) nxt = CONV;
      CONV: if (conv_last) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= OP_ADD;
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      disp     <= '0;
      done     <= 1'b0;
      result   <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opa   <= {{W{1'b0}}, a};
          opb   <= b;
          op_r  <= op;
          acc   <= '0;
          neg_r <= 1'b0;
          cnt   <= '0;
          bcd   <= '0;
        end
        CALC: begin
          cnt <= calc_last ? '0 : cnt + CW'(1);
          case (op_r)
            OP_ADD: acc <= {{W{1'b0}}, opa[W-1:0]} + {{W{1'b0}}, opb};
            OP_SUB: begin
              if (opa[W-1:0] < opb) begin
                acc   <= {{W{1'b0}}, opb - opa[W-1:0]};
                neg_r <= 1'b1;
              end else begin
                acc   <= {{W{1'b0}}, opa[W-1:0] - opb};
              end
            end
            OP_MUL: begin
              if (opb[0]) acc <= acc + opa;
              opa <= opa << 1;
              opb <= opb >> 1;
            end
            default: if (opb != '0) begin
              // restoring step: remainder in acc, dividend shifts out / quotient in
              if (rs >= {1'b0, opb}) begin
                acc        <= {{(W-1){1'b0}}, rs - {1'b0, opb}};
                opa[W-1:0] <= {opa[W-2:0], 1'b1};
              end else begin
                acc        <= {{(W-1){1'b0}}, rs};
                opa[W-1:0] <= {opa[W-2:0], 1'b0};
              end
            end
          endcase
        end
        CONV: begin
          // only the low DIGITS digits are kept; overflow covers the rest
          cnt <= conv_last ? '0 : cnt + CW'(1);
          bcd <= {bcd_adj[BW-2:0], mag_sh[2*W-1]};
        end
        DONE: begin
          done     <= 1'b1;
          result   <= mag;
          negative <= neg_r;
          overflow <= ovf_c;
          disp     <= bcd;
        end
        default: ;
      endcase
    end
  end

  logic [SW-1:0] sc_cnt;
  logic [DW-1:0] dig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt <= '0;
      dig    <= '0;
    end else if (sc_cnt == SW'(SCAN_DIV-1)) begin
      sc_cnt <= '0;
      dig    <= (dig == DW'(DIGITS-1)) ? '0 : dig + DW'(1);
    end else begin
      sc_cnt <= sc_cnt + SW'(1);
    end
  end

  assign an = ~(DIGITS'(1) << dig);

  logic blank;
`ifdef CALC_OVF_BLINK_EN
  logic [22:0] blink_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_cnt + 23'd1;
  end
  assign blank = blink_cnt[22];
`else
  assign blank = 1'b0;
`endif

  logic [3:0] cur;
  assign cur = disp[4*dig +: 4];

  always_comb begin
    seg = 7'h7F;
    if (overflow) begin
      if (!blank) begin
        case (dig)
          DW'(0):  seg = 7'b0101111;
          DW'(1):  seg = 7'b0000110;
          DW'(2):  seg = 7'b1000001;
          DW'(3):  seg = 7'b1000000;
          default: seg = 7'h7F;
        endcase
      end
    end else if (negative && dig == DW'(DIGITS-1)) begin
      seg = 7'b0111111;
    end else begin
      seg = dec7(cur);
    end
  end
endmodule

// File: tb/tb_calc_engine.sv
// Directed self-checking bench for calc_engine (W=7, DIGITS=4, SCAN_DIV=4).
module tb_calc_engine;
  localparam int W = 7, DIGITS = 4, SCAN_DIV = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic start = 1'b0;
  logic busy, done, negative, overflow;
  logic [2*W-1:0] result;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;
  int runs = 0, fails = 0;
  logic [6:0] cap [4];

  always #5 clk = ~clk;

  calc_engine #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .result(result), .negative(negative),
    .overflow(overflow), .seg(seg), .an(an)
  );

  task automatic capture();
    for (int k = 0; k < 4*SCAN_DIV; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  // lat = edges after the start-sample edge until done is seen high, -1 on timeout
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [1:0] iop, output int lat);
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    runs++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    runs++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    runs++; if (result !== '0) begin fails++; $display("FAIL reset_result got %0d exp 0", result); end
    runs++; if ({negative, overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {negative, overflow}); end
    runs++; if (an !== 4'b1110) begin fails++; $display("FAIL reset_an got %b exp 1110", an); end
    runs++; if (seg !== 7'b1000000) begin fails++; $display("FAIL reset_seg got %b exp 1000000", seg); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      exp_an = ~(4'b0001 << ((k / SCAN_DIV) % DIGITS));
      runs++; if (an !== exp_an) begin fails++; $display("FAIL scan_an[%0d] got %b exp %b", k, an, exp_an); end
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [27:0] expd;
    expd = {7'b1000000, 7'b1111001, 7'b0100100, 7'b1111000}; // 0127
    run_op(7'd100, 7'd27, 2'b00, lat);
    runs++; if (lat !== 16) begin fails++; $display("FAIL add_latency got %0d exp 16", lat); end
    runs++; if (result !== 14'd127) begin fails++; $display("FAIL add_result got %0d exp 127", result); end
    runs++; if ({negative, overflow} !== 2'b00) begin fails++; $display("FAIL add_flags got %b exp 00", {negative, overflow}); end
    runs++; if (busy !== 1'b0) begin fails++; $display("FAIL add_busy_at_done got %b exp 0", busy); end
    @(posedge clk); #1;
    runs++; if (done !== 1'b0) begin fails++; $display("FAIL add_done_pulse got %b exp 0", done); end
    capture();
    for (int k = 0; k < 4; k++) begin
      runs++; if (cap[k] !== expd[7*k +: 7]) begin fails++; $display("FAIL add_disp[%0d] got %b exp %b", k, cap[k], expd[7*k +: 7]); end
    end
    runs++; if (result !== 14'd127) begin fails++; $display("FAIL add_hold got %0d exp 127", result); end
  endtask

  task automatic test_sub();
    int lat;
    logic [27:0] expd;
    expd = {7'b0111111, 7'b1000000, 7'b0110000, 7'b0110000}; // -033
    run_op(7'd12, 7'd45, 2'b01, lat);
    runs++; if (lat !== 16) begin fails++; $display("FAIL sub_latency got %0d exp 16", lat); end
    runs++; if (result !== 14'd33) begin fails++; $display("FAIL sub_result got %0d exp 33", result); end
    runs++; if ({negative, overflow} !== 2'b10) begin fails++; $display("FAIL sub_flags got %b exp 10", {negative, overflow}); end
    capture();
    for (int k = 0; k < 4; k++) begin
      runs++; if (cap[k] !== expd[7*k +: 7]) begin fails++; $display("FAIL sub_disp[%0d] got %b exp %b", k, cap[k], expd[7*k +: 7]); end
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [27:0] expd;
    expd = {7'b1000000, 7'b1000001, 7'b0000110, 7'b0101111}; // OVEr
    run_op(7'd127, 7'd127, 2'b10, lat);
    runs++; if (lat !== 22) begin fails++; $display("FAIL mul_latency got %0d exp 22", lat); end
    runs++; if (result !== 14'd16129) begin fails++; $display("FAIL mul_result got %0d exp 16129", result); end
    runs++; if ({negative, overflow} !== 2'b01) begin fails++; $display("FAIL mul_flags got %b exp 01", {negative, overflow}); end
    capture();
    for (int k = 0; k < 4; k++) begin
      runs++; if (cap[k] !== expd[7*k +: 7]) begin fails++; $display("FAIL mul_disp[%0d] got %b exp %b", k, cap[k], expd[7*k +: 7]); end
    end
    run_op(7'd13, 7'd11, 2'b10, lat);
    runs++; if (result !== 14'd143 || overflow !== 1'b0) begin fails++; $display("FAIL mul_small got %0d/%b exp 143/0", result, overflow); end
  endtask

  task automatic test_div();
    int lat;
    logic [27:0] expd;
    expd = {7'b1000000, 7'b1000000, 7'b1111001, 7'b0011001}; // 0014
    run_op(7'd100, 7'd7, 2'b11, lat);
    runs++; if (lat !== 22) begin fails++; $display("FAIL div_latency got %0d exp 22", lat); end
    runs++; if (result !== 14'd14) begin fails++; $display("FAIL div_result got %0d exp 14", result); end
    runs++; if ({negative, overflow} !== 2'b00) begin fails++; $display("FAIL div_flags got %b exp 00", {negative, overflow}); end
    capture();
    for (int k = 0; k < 4; k++) begin
      runs++; if (cap[k] !== expd[7*k +: 7]) begin fails++; $display("FAIL div_disp[%0d] got %b exp %b", k, cap[k], expd[7*k +: 7]); end
    end
    run_op(7'd5, 7'd0, 2'b11, lat);
    runs++; if (lat !== 22) begin fails++; $display("FAIL divz_latency got %0d exp 22", lat); end
    runs++; if (overflow !== 1'b1) begin fails++; $display("FAIL divz_overflow got %b exp 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    first = -1; second = -1; pulses = 0;
    @(negedge clk);
    a = 7'd3; b = 7'd4; op = 2'b00; start = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first < 0) first = e; else if (second < 0) second = e;
      end
    end
    start = 1'b0;
    runs++; if (pulses !== 2) begin fails++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    runs++; if (second - first !== 17) begin fails++; $display("FAIL b2b_spacing got %0d exp 17", second - first); end
    runs++; if (result !== 14'd7) begin fails++; $display("FAIL b2b_result got %0d exp 7", result); end
    for (int i = 0; i < 40 && busy; i++) @(posedge clk);
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    @(negedge clk);
    a = 7'd127; b = 7'd127; op = 2'b10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    runs++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    runs++; if (seen !== 0) begin fails++; $display("FAIL abort_done got %0d pulses exp 0", seen); end
    runs++; if (result !== '0 || overflow !== 1'b0) begin fails++; $display("FAIL abort_result got %0d/%b exp 0/0", result, overflow); end
    runs++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
